// File: rtl/mips_trace_pkg.sv
// -----------------------------------------------------------------------------
// mips_trace_pkg
// Shared constants for the MIPS pipeline trace unit: the 5-bit instruction
// class codes, the opcode / funct values that select them, and CLS_W.
// Optional build macro used by mips_trace_buffer: MIPS_TRACE_CLASS_CNT_EN.
// -----------------------------------------------------------------------------
package mips_trace_pkg;

    localparam int CLS_W = 5;

    typedef enum logic [CLS_W-1:0] {
        CLS_NOP     = 5'd0,
        CLS_SLL     = 5'd1,
        CLS_ADD     = 5'd2,
        CLS_SUB     = 5'd3,
        CLS_AND     = 5'd4,
        CLS_OR      = 5'd5,
        CLS_SLT     = 5'd6,
        CLS_MULTU   = 5'd7,
        CLS_MFHI    = 5'd8,
        CLS_MFLO    = 5'd9,
        CLS_LW      = 5'd10,
        CLS_SW      = 5'd11,
        CLS_BEQ     = 5'd12,
        CLS_J       = 5'd13,
        CLS_ADDIU   = 5'd14,
        CLS_BNE     = 5'd15,
        CLS_UNKNOWN = 5'd30,
        CLS_INVALID = 5'd31
    } cls_e;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_ADDIU   = 6'd9;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_SW      = 6'd43;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL     = 6'd0;
    localparam logic [5:0] FN_MFHI    = 6'd16;
    localparam logic [5:0] FN_MFLO    = 6'd18;
    localparam logic [5:0] FN_MULTU   = 6'd25;
    localparam logic [5:0] FN_ADD     = 6'd32;
    localparam logic [5:0] FN_SUB     = 6'd34;
    localparam logic [5:0] FN_AND     = 6'd36;
    localparam logic [5:0] FN_OR      = 6'd37;
    localparam logic [5:0] FN_SLT     = 6'd42;

endpackage

// File: rtl/mips_instr_classify.sv
// -----------------------------------------------------------------------------
// mips_instr_classify
// Purely combinational mapping of one 32-bit MIPS instruction word to its
// 5-bit class code.
//   instr_i : instruction word
//   valid_i : stage holds a real instruction; 0 yields CLS_INVALID
//   cls_o   : class code (see mips_trace_pkg)
// -----------------------------------------------------------------------------
module mips_instr_classify
    import mips_trace_pkg::*;
(
    input  logic [31:0]      instr_i,
    input  logic             valid_i,
    output logic [CLS_W-1:0] cls_o
);

    // Decode opcode, then funct for SPECIAL; all-zero word is the canonical NOP
    always_comb begin
        cls_o = CLS_UNKNOWN;
        if (!valid_i) begin
            cls_o = CLS_INVALID;
        end else begin
            case (instr_i[31:26])
                OP_SPECIAL: begin
                    case (instr_i[5:0])
                        FN_SLL:   cls_o = (instr_i == 32'd0) ? CLS_NOP : CLS_SLL;
                        FN_ADD:   cls_o = CLS_ADD;
                        FN_SUB:   cls_o = CLS_SUB;
                        FN_AND:   cls_o = CLS_AND;
                        FN_OR:    cls_o = CLS_OR;
                        FN_SLT:   cls_o = CLS_SLT;
                        FN_MULTU: cls_o = CLS_MULTU;
                        FN_MFHI:  cls_o = CLS_MFHI;
                        FN_MFLO:  cls_o = CLS_MFLO;
                        default:  cls_o = CLS_UNKNOWN;
                    endcase
                end
                OP_LW:    cls_o = CLS_LW;
                OP_SW:    cls_o = CLS_SW;
                OP_BEQ:   cls_o = CLS_BEQ;
                OP_J:     cls_o = CLS_J;
                OP_ADDIU: cls_o = CLS_ADDIU;
                OP_BNE:   cls_o = CLS_BNE;
                default:  cls_o = CLS_UNKNOWN;
            endcase
        end
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// -----------------------------------------------------------------------------
// mips_trace_buffer
// Hardware trace unit for the MIPS pipeline. Every clock it samples PC and
// instruction of NUM_STAGES stages, classifies each instruction, and when
// tracing is active stores one record {cycle, stage-0 PC, classes} in a
// DEPTH-entry buffer drained over a ready/valid port.
//   clk, rst      : clock, asynchronous active-low reset
//   trc_en        : capture enable
//   circ_mode     : 0 = drop new record when full, 1 = overwrite oldest
//   stg_valid/pc/instr : per-stage taps (stage s at slice s)
//   rd_valid/rd_ready/rd_data : record drain port (rd_data = head entry)
//   level         : entries held
//   ovf, loss_cnt : sticky loss flag, saturating count of lost records
// Optional macro MIPS_TRACE_CLASS_CNT_EN adds cls_sel/cls_cnt: per-class
// counters (codes 0..15) of valid stage-0 instructions while trc_en=1.
// Timing: taps are registered at edge N, the record enters the buffer at
// edge N+1, so it is visible on rd_valid/rd_data after edge N+1.
// -----------------------------------------------------------------------------
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int DEPTH      = 16,
    parameter int PC_W       = 32,
    parameter int CYC_W      = 16,
    parameter int CNT_W      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  trc_en,
    input  logic                                  circ_mode,
    input  logic [NUM_STAGES-1:0]                 stg_valid,
    input  logic [NUM_STAGES*PC_W-1:0]            stg_pc,
    input  logic [NUM_STAGES*32-1:0]              stg_instr,
    output logic                                  rd_valid,
    input  logic                                  rd_ready,
    output logic [CYC_W+PC_W+CLS_W*NUM_STAGES-1:0] rd_data,
    output logic [$clog2(DEPTH):0]                level,
    output logic                                  ovf,
`ifdef MIPS_TRACE_CLASS_CNT_EN
    input  logic [CLS_W-1:0]                      cls_sel,
    output logic [CNT_W-1:0]                      cls_cnt,
`endif
    output logic [CNT_W-1:0]                      loss_cnt
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int CLS_VEC_W = CLS_W * NUM_STAGES;
    localparam int REC_W     = CYC_W + PC_W + CLS_VEC_W;

    logic [CLS_VEC_W-1:0] cls_vec_s;

    // One classifier per traced stage
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_cls
        mips_instr_classify u_cls (
            .instr_i (stg_instr[s*32 +: 32]),
            .valid_i (stg_valid[s]),
            .cls_o   (cls_vec_s[s*CLS_W +: CLS_W])
        );
    end

    // Only the stage-0 PC is recorded; later-stage PCs are tapped but unused
    if (NUM_STAGES > 1) begin : g_pc_hi
        logic pc_hi_unused_s;
        assign pc_hi_unused_s = ^stg_pc[NUM_STAGES*PC_W-1:PC_W];
    end

    logic [CYC_W-1:0] cyc_q;
    logic             smp_push_q;
    logic [REC_W-1:0] smp_rec_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [REC_W-1:0] mem_q [DEPTH];

    logic rd_valid_s, pop_s, full_s, wr_en_s, ovr_s, drop_s;

    assign rd_valid_s = (level_q != LVL_W'(0));
    assign pop_s      = rd_valid_s && rd_ready;
    assign full_s     = (level_q == LVL_W'(DEPTH));

    // Push arbitration: a pop in the same cycle always frees room for the push
    always_comb begin
        wr_en_s = 1'b0;
        ovr_s   = 1'b0;
        drop_s  = 1'b0;
        if (smp_push_q) begin
            if (!full_s || pop_s) begin
                wr_en_s = 1'b1;
            end else if (circ_mode) begin
                wr_en_s = 1'b1;
                ovr_s   = 1'b1;
            end else begin
                drop_s  = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state for pointers, fill level and loss tracking
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        loss_d   = loss_q;
        ovf_d    = ovf_q | ovr_s | drop_s;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        // Overwrite discards the oldest entry by advancing the read side
        if (pop_s || ovr_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // An overwrite replaces an entry, so it does not change the level
        case ({wr_en_s && !ovr_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if ((ovr_s || drop_s) && (loss_q != {CNT_W{1'b1}})) begin
            loss_d = loss_q + CNT_W'(1);
        end else begin
            loss_d = loss_q;
        end
    end

    // Cycle stamp, tap sampling register and buffer bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q      <= '0;
            smp_push_q <= 1'b0;
            smp_rec_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            loss_q     <= '0;
        end else begin
            cyc_q      <= cyc_q + CYC_W'(1);
            smp_push_q <= trc_en && (|stg_valid);
            smp_rec_q  <= {cyc_q, stg_pc[PC_W-1:0], cls_vec_s};
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            loss_q     <= loss_d;
        end
    end

    // Record storage; contents are don't-care while not covered by level
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= smp_rec_q;
        end
    end

    // Head entry is presented only while the buffer holds something
    always_comb begin
        if (rd_valid_s) begin
            rd_data = mem_q[rd_ptr_q];
        end else begin
            rd_data = '0;
        end
    end

    assign rd_valid = rd_valid_s;
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign loss_cnt = loss_q;

`ifdef MIPS_TRACE_CLASS_CNT_EN
    logic [CNT_W-1:0] cls_cnt_q [16];
    logic             cnt_hit_s;
    logic [3:0]       cnt_idx_s;

    // Codes 16..31 (UNKNOWN/INVALID) have no counter
    assign cnt_hit_s = trc_en && stg_valid[0] && !cls_vec_s[CLS_W-1];
    assign cnt_idx_s = cls_vec_s[3:0];

    // Saturating per-class counters for stage 0, independent of buffer state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                cls_cnt_q[i] <= '0;
            end
        end else if (cnt_hit_s && (cls_cnt_q[cnt_idx_s] != {CNT_W{1'b1}})) begin
            cls_cnt_q[cnt_idx_s] <= cls_cnt_q[cnt_idx_s] + CNT_W'(1);
        end
    end

    // Counter readback; selections above 15 read as zero
    always_comb begin
        if (cls_sel[CLS_W-1] == 1'b0) begin
            cls_cnt = cls_cnt_q[cls_sel[3:0]];
        end else begin
            cls_cnt = '0;
        end
    end
`endif

endmodule

// File: tb/tb_mips_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_mips_trace_buffer
// Directed bench for mips_trace_buffer. Stimulus declares the hand-computed
// record for each sampled cycle; a queue model moves it into the expected
// buffer contents on the write edge, and a negedge monitor compares the
// DUT head/valid/level against the queue.
// -----------------------------------------------------------------------------
module tb_mips_trace_buffer;

    localparam int NS     = 2;
    localparam int DEPTH  = 16;
    localparam int PC_W   = 32;
    localparam int CYC_W  = 16;
    localparam int CNT_W  = 32;
    localparam int CLSV_W = 5 * NS;
    localparam int REC_W  = CYC_W + PC_W + CLSV_W;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 trc_en = 1'b0;
    logic                 circ_mode = 1'b0;
    logic [NS-1:0]        stg_valid = '0;
    logic [NS*PC_W-1:0]   stg_pc = '0;
    logic [NS*32-1:0]     stg_instr = '0;
    logic                 rd_valid;
    logic                 rd_ready = 1'b0;
    logic [REC_W-1:0]     rd_data;
    logic [$clog2(DEPTH):0] level;
    logic                 ovf;
    logic [CNT_W-1:0]     loss_cnt;
`ifdef MIPS_TRACE_CLASS_CNT_EN
    logic [4:0]           cls_sel = 5'd0;
    logic [CNT_W-1:0]     cls_cnt;
`endif

    mips_trace_buffer #(
        .NUM_STAGES (NS),
        .DEPTH      (DEPTH),
        .PC_W       (PC_W),
        .CYC_W      (CYC_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trc_en    (trc_en),
        .circ_mode (circ_mode),
        .stg_valid (stg_valid),
        .stg_pc    (stg_pc),
        .stg_instr (stg_instr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .level     (level),
        .ovf       (ovf),
`ifdef MIPS_TRACE_CLASS_CNT_EN
        .cls_sel   (cls_sel),
        .cls_cnt   (cls_cnt),
`endif
        .loss_cnt  (loss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [REC_W-1:0] sb [$];
    logic             exp_v_next = 1'b0;
    logic [REC_W-1:0] exp_rec_next = '0;
    logic             pend_v = 1'b0;
    logic [REC_W-1:0] pend_rec = '0;
    int               exp_loss = 0;
    logic [CYC_W-1:0] tb_cyc = '0;

    logic [31:0] cls_words [10];
    logic [4:0]  cls_exp   [10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference cycle count: DUT counter value at each sampling edge
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cyc <= '0;
        else      tb_cyc <= tb_cyc + 16'd1;
    end

    // Queue model: sample edge registers the declared record, next edge stores it
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb.delete();
            pend_v   = 1'b0;
            exp_loss = 0;
        end else begin
            if (rd_ready && sb.size() != 0) void'(sb.pop_front());
            if (pend_v) begin
                if (sb.size() < DEPTH) begin
                    sb.push_back(pend_rec);
                end else if (circ_mode) begin
                    void'(sb.pop_front());
                    sb.push_back(pend_rec);
                    exp_loss++;
                end else begin
                    exp_loss++;
                end
            end
            pend_v   = exp_v_next;
            pend_rec = exp_rec_next;
        end
    end

    // Monitor: head, valid and level against the model, away from the edge
    always @(negedge clk) begin
        if (rst) begin
            check("rd_valid", {63'd0, rd_valid}, {63'd0, sb.size() != 0});
            check("level", 64'(level), 64'(sb.size()));
            if (rd_valid && sb.size() != 0) begin
                check("rd_data", 64'(rd_data), 64'(sb[0]));
            end
        end
    end

    // Drive one cycle of taps plus the record it should produce
    task automatic step(input logic te, input logic [1:0] v, input logic [31:0] pc0,
                        input logic [31:0] i0, input logic [31:0] i1,
                        input logic [4:0] c0, input logic [4:0] c1, input logic rdy);
        trc_en       = te;
        stg_valid    = v;
        stg_pc       = {32'hDEAD_0000, pc0};
        stg_instr    = {i1, i0};
        rd_ready     = rdy;
        exp_v_next   = te && (|v);
        exp_rec_next = {tb_cyc, pc0, c1, c0};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd31, 5'd31, rdy);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && (sb.size() != 0 || pend_v); k++) idle(1'b1);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
    endtask

    // Pulse reset away from the clock edge and check outputs clear at once
    task automatic do_reset(input string nm);
        idle(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check({nm, "_rd_valid"}, {63'd0, rd_valid}, 64'd0);
        check({nm, "_rd_data"}, 64'(rd_data), 64'd0);
        check({nm, "_level"}, 64'(level), 64'd0);
        check({nm, "_ovf"}, {63'd0, ovf}, 64'd0);
        check({nm, "_loss"}, 64'(loss_cnt), 64'd0);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic circ);
        circ_mode = circ;
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b1, 2'b01, 32'(32'h1000 + 4 * i), 32'd0, 32'd0, 5'd0, 5'd31, 1'b0);
        end
        idle(1'b0);
        idle(1'b0);
    endtask

    initial begin
        cls_words = '{32'h8C020004, 32'hAC020004, 32'h10220003, 32'h08000010, 32'h2402FFFF,
                      32'h14220001, 32'hFC000000, 32'h00084080, 32'h01095022, 32'h00004012};
        cls_exp   = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd30, 5'd1, 5'd3, 5'd9};

        #1 rst = 1'b0;
        #10;
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_loss", 64'(loss_cnt), 64'd0);
        #16 rst = 1'b1;
        @(posedge clk);
        #1;

        // ADD on stage 0, all-zero word on stage 1; first record at cycle 1
        check("first_cycle_stamp", 64'(tb_cyc), 64'd1);
        step(1'b1, 2'b11, 32'h0040_0000, 32'h012A4020, 32'h0, 5'd2, 5'd0, 1'b1);
        check("latency_not_yet", {63'd0, rd_valid}, 64'd0);
        idle(1'b0);
        check("latency_valid", {63'd0, rd_valid}, 64'd1);
        check("first_record", 64'(rd_data), 64'({16'd1, 32'h0040_0000, 5'd0, 5'd2}));
        drain();

        // Class decode vectors, then an invalid stage 0
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'b11, 32'(32'h0040_0100 + 4 * i), cls_words[i], 32'd0, cls_exp[i], 5'd0, 1'b1);
        end
        step(1'b1, 2'b10, 32'h0040_0200, 32'h8C020004, 32'h012A4020, 5'd31, 5'd2, 1'b1);
        step(1'b0, 2'b11, 32'h0040_0204, 32'h012A4020, 32'h0, 5'd2, 5'd0, 1'b1);
        drain();

        // Stream mode overflow: the first DEPTH records survive
        do_reset("rst_a");
        fill(1'b0);
        check("stream_level", 64'(level), 64'(DEPTH));
        check("stream_loss", 64'(loss_cnt), 64'd3);
        check("stream_ovf", {63'd0, ovf}, 64'd1);
        check("stream_head_pc", 64'(rd_data[CLSV_W +: PC_W]), 64'h1000);
        check("stream_loss_model", 64'(loss_cnt), 64'(exp_loss));
        drain();
        check("stream_ovf_sticky", {63'd0, ovf}, 64'd1);

        // Circular mode overflow: head is push #4
        do_reset("rst_b");
        fill(1'b1);
        check("circ_level", 64'(level), 64'(DEPTH));
        check("circ_loss", 64'(loss_cnt), 64'd3);
        check("circ_ovf", {63'd0, ovf}, 64'd1);
        check("circ_head_pc", 64'(rd_data[CLSV_W +: PC_W]), 64'h100C);

        // Full buffer: push and pop on the same edge loses nothing
        step(1'b1, 2'b01, 32'h2000, 32'd0, 32'd0, 5'd0, 5'd31, 1'b0);
        idle(1'b1);
        idle(1'b0);
        check("full_pushpop_level", 64'(level), 64'(DEPTH));
        check("full_pushpop_loss", 64'(loss_cnt), 64'd3);
        check("full_pushpop_head", 64'(rd_data[CLSV_W +: PC_W]), 64'h1010);

        // Reset in the middle of draining
        idle(1'b1);
        idle(1'b1);
        do_reset("rst_mid");
        check("post_rst_level", 64'(level), 64'd0);

`ifdef MIPS_TRACE_CLASS_CNT_EN
        // 5 ADD + 2 LW on stage 0, plus an invalid-stage-0 cycle that must not count
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 32'h3000, 32'h012A4020, 32'd0, 5'd2, 5'd31, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 2'b01, 32'h3004, 32'h8C020004, 32'd0, 5'd10, 5'd31, 1'b1);
        step(1'b1, 2'b10, 32'h3008, 32'h012A4020, 32'h012A4020, 5'd31, 5'd2, 1'b1);
        drain();
        cls_sel = 5'd2;
        #1 check("cls_cnt_add", 64'(cls_cnt), 64'd5);
        cls_sel = 5'd10;
        #1 check("cls_cnt_lw", 64'(cls_cnt), 64'd2);
        cls_sel = 5'd20;
        #1 check("cls_cnt_out_of_range", 64'(cls_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Synthesizable pipeline trace unit for the MIPS pipeline: samples PC and instruction word from NUM_STAGES pipeline stages every clock, classifies each instruction into a mnemonic class code, and stores one timestamped record per active cycle in a DEPTH-entry buffer drained over a ready/valid port. It replaces simulation-only `$display` tracing of fetch/decode with hardware that also works on silicon/FPGA, and sits beside `mips_pipeline`, tapping stage registers read-only.

## Interface
- NUM_STAGES, 2, stages traced; stage 0 = fetch, 1 = decode, higher = later stages
- DEPTH, 16, record buffer entries; power of two, ≥2
- PC_W, 32, PC width
- CYC_W, 16, cycle-stamp width
- CNT_W, 32, width of drop/overwrite and class counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- trc_en  in  1  capture enable
- circ_mode  in  1  0 = stream (drop new when full), 1 = circular (overwrite oldest)
- stg_valid  in  NUM_STAGES  per-stage valid
- stg_pc  in  NUM_STAGES*PC_W  per-stage PC, stage s at [s*PC_W +: PC_W]
- stg_instr  in  NUM_STAGES*32  per-stage instruction word
- rd_valid  out  1  record available
- rd_ready  in  1  consumer accepts record
- rd_data  out  CYC_W+PC_W+5*NUM_STAGES  {cycle, stage-0 PC, class[NUM_STAGES-1..0]}
- level  out  $clog2(DEPTH)+1  entries held
- ovf  out  1  sticky: any record dropped or overwritten since reset
- loss_cnt  out  CNT_W  records dropped (stream) or overwritten (circular)

## Operation
- Class codes (5 bits): NOP=0, SLL=1, ADD=2, SUB=3, AND=4, OR=5, SLT=6, MULTU=7, MFHI=8, MFLO=9, LW=10, SW=11, BEQ=12, J=13, ADDIU=14, BNE=15, UNKNOWN=30, INVALID=31.
- Decode: opcode 0 → by funct (0→NOP if word==0 else SLL; 32,34,36,37,42,25,16,18); opcodes 35,43,4,2,9,5 → LW,SW,BEQ,J,ADDIU,BNE; anything else UNKNOWN; stage with stg_valid=0 → INVALID.
- Free-running cycle counter: 0 after reset, +1 every clock, wraps modulo 2^CYC_W, unaffected by trc_en.
- Push condition: trc_en=1 and at least one stg_valid bit set. Record carries the cycle counter value of the sampling cycle.
- Pop: rd_valid && rd_ready; rd_valid = (level != 0).
- Full, no pop, stream mode: new record discarded, loss_cnt+1, ovf=1.
- Full, no pop, circular mode: oldest entry discarded (read pointer advances), new one written, level stays DEPTH, loss_cnt+1, ovf=1.
- Full with simultaneous pop: both occur, no loss, either mode.
- Empty with simultaneous push: push only; rd_valid rises next cycle (no bypass).
- loss_cnt saturates at all-ones. circ_mode change takes effect on the next push; buffer contents retained.

## Timing
- Reset values: rd_valid=0, rd_data=0, level=0, ovf=0, loss_cnt=0, cycle counter=0, pointers=0.
- Reset asserted mid-operation clears all state immediately; buffered records lost.
- Latency: record sampled at edge N visible on rd_data/rd_valid after edge N+1.
- rd_data is the head entry, stable while rd_valid=1 and rd_ready=0 unless circular overwrite advances the head (head then changes to next oldest).
- Throughput: one push and one pop per cycle.

## Configuration
- MIPS_TRACE_CLASS_CNT_EN defined: adds inputs cls_sel (5 bits) and output cls_cnt (CNT_W): one saturating counter per class code 0–15 counting every valid stage-0 instruction while trc_en=1 (independent of buffer fullness); cls_cnt returns counter[cls_sel] combinationally, 0 for cls_sel>15; counters reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package mips_trace_pkg: class-code localparams/enum, opcode and funct constants, CLS_W=5.
- Sub-module mips_instr_classify: combinational 32-bit word + valid → class code; instantiated NUM_STAGES times via generate.
- Buffer is plain RAM array + pointers + level counter inside mips_trace_buffer.

## Test plan
- Reset, stage0 instr 0x012A4020 (ADD) valid, stage1 word 0 valid, rd_ready=1 → next cycle rd_valid=1, classes {NOP=0, ADD=2}, cycle field=sample cycle.
- Stage0 words 0x8C020004, 0xAC020004, 0x10220003, 0x08000010, 0x2402FFFF, 0x14220001, 0xFC000000 → classes 10,11,12,13,14,15,30; stage valid=0 → 31.
- Stream mode, rd_ready=0, DEPTH+3 pushes → level=DEPTH, loss_cnt=3, ovf=1, drained records are the first DEPTH in order.
- Circular mode, same stimulus → level=DEPTH, loss_cnt=3, first drained record is push #4.
- Full buffer, push and pop same cycle → level stays DEPTH, loss_cnt unchanged; rst low mid-drain → all outputs zero asynchronously.
- With MIPS_TRACE_CLASS_CNT_EN: 5 ADD + 2 LW on stage 0 → cls_sel=2 gives 5, cls_sel=10 gives 2, cls_sel=20 gives 0.
